// File: rtl/br_stat_mmio.sv
// rtl/br_stat_mmio.sv - branch-prediction statistics counters behind a 16-bit MMIO window
`timescale 1ns/1ps
module br_stat_mmio #(
  parameter logic [15:0] BASE_ADDR = 16'hC010,
  parameter int          CNT_W     = 32,
  parameter logic        EN_RST    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mm_we,
  input  logic        mm_re,
  output logic [15:0] rdata,
  input  logic        inc_br_cnt,
  input  logic        inc_hit_cnt,
  input  logic        inc_mispr_cnt
);

  localparam int HI_W = CNT_W - 16;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             sel, rd, wr;
  logic [3:0]       off;
  logic             enable, freeze;
  logic [3:0]       status;
  logic [CNT_W-1:0] br_cnt, hit_cnt, mispr_cnt, cyc_cnt;
  logic [HI_W-1:0]  br_sh, hit_sh, mispr_sh, cyc_sh;
  logic             active, ctrl_wr, clr, stat_wr;
  logic [3:0]       inc, wrap, w1c, cap;
  logic             unused_wdata;

  // Address decode: the block owns a 16-register window at BASE_ADDR
  assign sel     = (addr[15:4] == BASE_ADDR[15:4]);
  assign off     = addr[3:0];
  assign rd      = sel & mm_re;
  assign wr      = sel & mm_we;
  assign ctrl_wr = wr & (off == 4'd0);
  assign stat_wr = wr & (off == 4'd1);
  assign clr     = ctrl_wr & wdata[1];
  assign w1c     = stat_wr ? wdata[3:0] : 4'b0000;
  assign unused_wdata = ^wdata[15:4];

  // Event vector ordered {CYC, MISPR, HIT, BR}; pulses are dropped while inactive
  assign active = enable & ~freeze;
  assign inc    = {4{active}} & {1'b1, inc_mispr_cnt, inc_hit_cnt, inc_br_cnt};
  assign wrap   = inc & {&cyc_cnt, &mispr_cnt, &hit_cnt, &br_cnt};

  // A lo read latches the matching upper half so a following hi read is coherent
  assign cap = {4{rd}} & {off == 4'd8, off == 4'd6, off == 4'd4, off == 4'd2};

  // CTRL register: enable/freeze take the written bits; clear is a pulse, never stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable <= EN_RST;
      freeze <= 1'b0;
    end else if (ctrl_wr) begin
      enable <= wdata[0];
      freeze <= wdata[2];
    end
  end

  // Event counters: clear overrides any increment on the same edge, wrap is modular
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt    <= '0;
      hit_cnt   <= '0;
      mispr_cnt <= '0;
      cyc_cnt   <= '0;
    end else if (clr) begin
      br_cnt    <= '0;
      hit_cnt   <= '0;
      mispr_cnt <= '0;
      cyc_cnt   <= '0;
    end else begin
      if (inc[0]) br_cnt    <= br_cnt + CNT_ONE;
      if (inc[1]) hit_cnt   <= hit_cnt + CNT_ONE;
      if (inc[2]) mispr_cnt <= mispr_cnt + CNT_ONE;
      if (inc[3]) cyc_cnt   <= cyc_cnt + CNT_ONE;
    end
  end

  // Shadow registers hold the pre-increment upper bits seen by the last lo read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_sh    <= '0;
      hit_sh   <= '0;
      mispr_sh <= '0;
      cyc_sh   <= '0;
    end else if (clr) begin
      br_sh    <= '0;
      hit_sh   <= '0;
      mispr_sh <= '0;
      cyc_sh   <= '0;
    end else begin
      if (cap[0]) br_sh    <= br_cnt[CNT_W-1:16];
      if (cap[1]) hit_sh   <= hit_cnt[CNT_W-1:16];
      if (cap[2]) mispr_sh <= mispr_cnt[CNT_W-1:16];
      if (cap[3]) cyc_sh   <= cyc_cnt[CNT_W-1:16];
    end
  end

  // Sticky overflow flags: a wrap on the same edge as a W1C keeps the bit set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= 4'b0000;
    end else if (clr) begin
      status <= 4'b0000;
    end else begin
      status <= (status & ~w1c) | wrap;
    end
  end

  // Read mux: combinational, zero whenever the block is not the read target
  always_comb begin
    rdata = 16'h0000;
    if (rd) begin
      case (off)
        4'd0:    rdata = {13'b0, freeze, 1'b0, enable};
        4'd1:    rdata = {12'b0, status};
        4'd2:    rdata = br_cnt[15:0];
        4'd3:    rdata = 16'(br_sh);
        4'd4:    rdata = hit_cnt[15:0];
        4'd5:    rdata = 16'(hit_sh);
        4'd6:    rdata = mispr_cnt[15:0];
        4'd7:    rdata = 16'(mispr_sh);
        4'd8:    rdata = cyc_cnt[15:0];
        4'd9:    rdata = 16'(cyc_sh);
        default: rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_br_stat_mmio.sv
// tb/tb_br_stat_mmio.sv - randomized model-checked bench for br_stat_mmio
`timescale 1ns/1ps
module tb_br_stat_mmio;

  localparam int CNT_W = 32;
  localparam longint unsigned MASK = (64'd1 << CNT_W) - 64'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        mm_we = 1'b0;
  logic        mm_re = 1'b0;
  logic [15:0] rdata;
  logic        inc_br_cnt = 1'b0;
  logic        inc_hit_cnt = 1'b0;
  logic        inc_mispr_cnt = 1'b0;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  longint unsigned m_cnt [4];
  longint unsigned m_sh  [4];
  bit [3:0]        m_st;
  bit              m_en;
  bit              m_fz;
  logic [CNT_W-1:0] fv;

  br_stat_mmio #(.BASE_ADDR(16'hC010), .CNT_W(CNT_W), .EN_RST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .mm_we(mm_we), .mm_re(mm_re),
    .rdata(rdata), .inc_br_cnt(inc_br_cnt), .inc_hit_cnt(inc_hit_cnt), .inc_mispr_cnt(inc_mispr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: rdata=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counters as plain integers modulo 2^CNT_W
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0;
      m_sh[i]  = 0;
    end
    m_st = 4'b0000;
    m_en = 1'b1;
    m_fz = 1'b0;
  endtask

  task automatic model_step();
    bit       s;
    int       o;
    bit [3:0] ev;
    bit [3:0] wraps;
    s  = (addr[15:4] == 12'hC01);
    o  = int'(addr[3:0]);
    if (s && mm_re && o >= 2 && o <= 9 && (o % 2) == 0)
      m_sh[(o - 2) / 2] = m_cnt[(o - 2) / 2] >> 16;
    ev = {1'b1, inc_mispr_cnt, inc_hit_cnt, inc_br_cnt};
    wraps = 4'b0000;
    if (m_en && !m_fz) begin
      for (int i = 0; i < 4; i++) begin
        if (ev[i]) begin
          if (m_cnt[i] == MASK) begin
            m_cnt[i] = 0;
            wraps[i] = 1'b1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
    end
    if (s && mm_we && o == 1) m_st = m_st & ~wdata[3:0];
    m_st = m_st | wraps;
    if (s && mm_we && o == 0) begin
      m_en = wdata[0];
      m_fz = wdata[2];
      if (wdata[1]) begin
        for (int i = 0; i < 4; i++) begin
          m_cnt[i] = 0;
          m_sh[i]  = 0;
        end
        m_st = 4'b0000;
      end
    end
  endtask

  function automatic logic [15:0] model_rdata();
    int o;
    if (!(addr[15:4] == 12'hC01 && mm_re)) return 16'h0000;
    o = int'(addr[3:0]);
    if (o == 0) return {13'b0, m_fz, 1'b0, m_en};
    if (o == 1) return {12'b0, m_st};
    if (o >= 2 && o <= 9 && (o % 2) == 0) return 16'(m_cnt[(o - 2) / 2]);
    if (o >= 3 && o <= 9) return 16'(m_sh[(o - 3) / 2]);
    return 16'h0000;
  endfunction

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Every cycle, the DUT read data must match the model
  always @(negedge clk) begin
    if (chk_on) check("model_rdata", rdata, model_rdata());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
    addr  = a;
    mm_re = 1'b1;
    @(negedge clk);
    check(name, rdata, exp);
    step();
    mm_re = 1'b0;
    addr  = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    mm_we = 1'b1;
    step();
    mm_we = 1'b0;
    addr  = 16'h0000;
    wdata = 16'h0000;
  endtask

  task automatic pulse(input int n, input bit b, input bit h, input bit m);
    for (int i = 0; i < n; i++) begin
      inc_br_cnt = b; inc_hit_cnt = h; inc_mispr_cnt = m;
      step();
    end
    inc_br_cnt = 1'b0; inc_hit_cnt = 1'b0; inc_mispr_cnt = 1'b0;
  endtask

  // Deposit a counter value between clock edges; the model is updated to match
  task automatic preload(input int idx, input longint unsigned val);
    fv = val[CNT_W-1:0];
    case (idx)
      0: force dut.br_cnt = fv;
      1: force dut.hit_cnt = fv;
      2: force dut.mispr_cnt = fv;
      default: force dut.cyc_cnt = fv;
    endcase
    #1;
    case (idx)
      0: release dut.br_cnt;
      1: release dut.hit_cnt;
      2: release dut.mispr_cnt;
      default: release dut.cyc_cnt;
    endcase
    m_cnt[idx] = val;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;

    // Reads while held in reset
    rd(16'hC010, 16'h0001, "rst_ctrl");
    for (int o = 2; o <= 9; o++) rd(16'hC010 + 16'(o), 16'h0000, "rst_cnt");
    rd(16'hC011, 16'h0000, "rst_status");
    rd(16'hC01F, 16'h0000, "rst_off15");
    rst_n = 1'b1;

    // Basic counting
    pulse(5, 1'b1, 1'b0, 1'b0);
    pulse(3, 1'b0, 1'b1, 1'b1);
    rd(16'hC012, 16'h0005, "br_lo_5");
    rd(16'hC014, 16'h0003, "hit_lo_3");
    rd(16'hC016, 16'h0003, "mispr_lo_3");
    rd(16'h8010, 16'h0000, "unselected");
    rd(16'hC01A, 16'h0000, "off10");

    // Shadow capture across the 16-bit boundary
    preload(0, 64'h0000_FFFF);
    inc_br_cnt = 1'b1;
    rd(16'hC012, 16'hFFFF, "br_lo_ffff");
    inc_br_cnt = 1'b0;
    rd(16'hC013, 16'h0000, "br_hi_pre");
    rd(16'hC012, 16'h0000, "br_lo_after");
    rd(16'hC013, 16'h0001, "br_hi_post");

    // Freeze holds everything, resume restarts counting
    wr(16'hC010, 16'h0005);
    rd(16'hC010, 16'h0005, "ctrl_freeze");
    pulse(10, 1'b1, 1'b1, 1'b1);
    rd(16'hC012, 16'h0000, "frz_br");
    rd(16'hC014, 16'h0003, "frz_hit");
    rd(16'hC016, 16'h0003, "frz_mispr");
    wr(16'hC012, 16'h1234);
    rd(16'hC012, 16'h0000, "cnt_write_ignored");
    wr(16'hC010, 16'h0001);
    pulse(4, 1'b1, 1'b0, 1'b0);
    rd(16'hC012, 16'h0004, "resume_br");

    // Wrap and sticky status
    preload(0, MASK);
    pulse(1, 1'b1, 1'b0, 1'b0);
    rd(16'hC012, 16'h0000, "wrap_br_lo");
    rd(16'hC013, 16'h0000, "wrap_br_hi");
    rd(16'hC011, 16'h0001, "wrap_status");
    preload(0, MASK);
    inc_br_cnt = 1'b1;
    wr(16'hC011, 16'h0001);
    inc_br_cnt = 1'b0;
    rd(16'hC011, 16'h0001, "w1c_vs_wrap");
    wr(16'hC011, 16'h0001);
    rd(16'hC011, 16'h0000, "w1c_alone");

    // Clear beats a simultaneous increment
    preload(1, MASK);
    pulse(1, 1'b0, 1'b1, 1'b0);
    rd(16'hC011, 16'h0002, "hit_wrap_status");
    inc_br_cnt = 1'b1;
    wr(16'hC010, 16'h0003);
    inc_br_cnt = 1'b0;
    rd(16'hC018, 16'h0000, "clr_cyc");
    rd(16'hC012, 16'h0000, "clr_br");
    rd(16'hC011, 16'h0000, "clr_status");
    rd(16'hC010, 16'h0001, "clr_ctrl");

    // Randomized traffic checked against the model each cycle
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [15:0] d;
      r = int'($urandom_range(0, 99));
      if (r >= 50 && r < 53)
        preload(int'($urandom_range(0, 3)), MASK - longint'($urandom_range(0, 3)));
      inc_br_cnt    = 1'($urandom);
      inc_hit_cnt   = 1'($urandom);
      inc_mispr_cnt = 1'($urandom);
      if (r < 40) begin
        addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : {12'hC01, 4'($urandom)};
        mm_re = 1'b1;
      end else if (r < 50) begin
        d    = 16'($urandom);
        d[0] = ($urandom_range(0, 3) != 0);
        d[1] = ($urandom_range(0, 19) == 0);
        d[2] = ($urandom_range(0, 3) == 0);
        addr  = {12'hC01, ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1))};
        wdata = d;
        mm_we = 1'b1;
      end
      step();
      mm_re = 1'b0; mm_we = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    end
    inc_br_cnt = 1'b0; inc_hit_cnt = 1'b0; inc_mispr_cnt = 1'b0;

    // Asynchronous reset mid-read
    wr(16'hC010, 16'h0004);
    pulse(3, 1'b1, 1'b1, 1'b1);
    addr  = 16'hC018;
    mm_re = 1'b1;
    inc_br_cnt = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cyc", rdata, 16'h0000);
    addr = 16'hC010;
    #1;
    check("async_rst_ctrl", rdata, 16'h0001);
    step();
    mm_re = 1'b0; addr = 16'h0000; inc_br_cnt = 1'b0;
    rst_n = 1'b1;
    rd(16'hC012, 16'h0000, "post_rst_br");
    rd(16'hC011, 16'h0000, "post_rst_status");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
